// File: rtl/qam16_polar_demapper.sv
// qam16_polar_demapper
// Hard-decision 16-QAM demapper fed by the CORDIC vectoring stage (magnitude
// and phase). Each accepted sample is sliced into a Gray-coded 4-bit symbol
// and buffered in a small FIFO. A serializer then streams each symbol MSB-first.
// Optional feature: define QAM_DEMAP_STATS_EN to add the per-ring decision
// counters ring_cnt0/1/2.
//
// Handshake: a bit transfers on any rising edge where bit_valid && bit_ready.
// bit_out stays stable while bit_valid=1 and bit_ready=0. Upstream has no
// back-pressure: in_valid is a one-cycle strobe that is always accepted.
module qam16_polar_demapper #(
  parameter int                    WIDTH      = 16,
  parameter int                    WIDTH_WIRE = 18,
  parameter logic [WIDTH_WIRE-1:0] THR_LO     = 18'd7719,
  parameter logic [WIDTH_WIRE-1:0] THR_HI     = 18'd12489,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [WIDTH_WIRE-1:0] mag_in,
  input  logic [WIDTH-1:0]      phase_in,
  output logic                  bit_out,
  output logic                  bit_valid,
  input  logic                  bit_ready,
  output logic [3:0]            sym_out,
  output logic                  sym_valid,
  output logic                  ovf,
  output logic                  dbg_state_o
`ifdef QAM_DEMAP_STATS_EN
  ,
  output logic [15:0]           ring_cnt0,
  output logic [15:0]           ring_cnt1,
  output logic [15:0]           ring_cnt2
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = WIDTH + 2;

  // Quadrant boundaries on the phase (pi = 25735).
  localparam logic [WIDTH-1:0]     PH_B1  = WIDTH'(12868);
  localparam logic [WIDTH-1:0]     PH_B2  = WIDTH'(25735);
  localparam logic [WIDTH-1:0]     PH_B3  = WIDTH'(38603);
  localparam logic [OW-1:0]        QSTEP  = OW'(12868);
  localparam logic signed [OW-1:0] NEAR_T = OW'(6434);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  // ---------------- Stage 1: ring / quadrant / near slicing ----------------
  logic [1:0]            ring_d, quad_d;
  logic                  near_d;
  logic [OW-1:0]         base_w;
  logic signed [OW-1:0]  off_w;

  logic                  s1_valid_q;
  logic [1:0]            ring_q, quad_q;
  logic                  near_q;

  // Slice the incoming sample; the offset is signed so that a phase just
  // below a quadrant's nominal start (q*12868) counts as near that start.
  always_comb begin
    ring_d = 2'd2;
    if (mag_in < THR_LO)      ring_d = 2'd0;
    else if (mag_in < THR_HI) ring_d = 2'd1;

    quad_d = 2'd3;
    if (phase_in < PH_B1)      quad_d = 2'd0;
    else if (phase_in < PH_B2) quad_d = 2'd1;
    else if (phase_in < PH_B3) quad_d = 2'd2;

    base_w = QSTEP * OW'(quad_d);
    off_w  = $signed(OW'(phase_in)) - $signed(base_w);
    near_d = (off_w < NEAR_T);
  end

  // Stage 1 register: captures the slice on every in_valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      ring_q     <= 2'd0;
      quad_q     <= 2'd0;
      near_q     <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        ring_q <= ring_d;
        quad_q <= quad_d;
        near_q <= near_d;
      end
    end
  end

  // ---------------- Stage 2: levels, signs and Gray coding ----------------
  logic       i_big, q_big, i_pos, q_pos;
  logic [3:0] sym_d;
  logic [3:0] sym_q;
  logic       sym_valid_q;

  // Per-axis Gray code is {positive, small}: -3=00, -1=01, +1=11, +3=10.
  always_comb begin
    i_big = 1'b0;
    q_big = 1'b0;
    case (ring_q)
      2'd0: begin
        i_big = 1'b0;
        q_big = 1'b0;
      end
      2'd1: begin
        // Even quadrants lean towards the I axis near their start, odd ones
        // towards the Q axis.
        i_big = near_q ^ quad_q[0];
        q_big = ~(near_q ^ quad_q[0]);
      end
      default: begin
        i_big = 1'b1;
        q_big = 1'b1;
      end
    endcase
    i_pos = ~(quad_q[1] ^ quad_q[0]);
    q_pos = ~quad_q[1];
    sym_d = {i_pos, ~i_big, q_pos, ~q_big};
  end

  // Stage 2 register: holds the last decision and pulses sym_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_q       <= 4'd0;
      sym_valid_q <= 1'b0;
    end else begin
      sym_valid_q <= s1_valid_q;
      if (s1_valid_q) sym_q <= sym_d;
    end
  end

  assign sym_out   = sym_q;
  assign sym_valid = sym_valid_q;

  // ---------------- Symbol FIFO ----------------
  logic [3:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] fill_w;
  logic        full_w, empty_w, push_w, drop_w, pop_w;
  logic [3:0]  head_w;
  logic        ovf_q;

  // FIFO status; a full FIFO still accepts a push when it pops on the same edge.
  always_comb begin
    fill_w  = wr_ptr_q - rd_ptr_q;
    full_w  = (fill_w == (AW+1)'(FIFO_DEPTH));
    empty_w = (fill_w == '0);
    head_w  = mem_q[rd_ptr_q[AW-1:0]];
    push_w  = sym_valid_q && (!full_w || pop_w);
    drop_w  = sym_valid_q && full_w && !pop_w;
  end

  // FIFO storage, no reset needed: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_ptr_q[AW-1:0]] <= sym_q;
  end

  // FIFO pointers and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop_w) ovf_q    <= 1'b1;
    end
  end

  assign ovf = ovf_q;

  // ---------------- Serializer FSM ----------------
  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] shreg_q, shreg_d;

  // Serializer next state and outputs; reloads on the last bit so that
  // back-to-back symbols stream without a bubble.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    pop_w     = 1'b0;
    bit_valid = 1'b0;
    bit_out   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_w) begin
          pop_w   = 1'b1;
          shreg_d = head_w;
          cnt_d   = 2'd3;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bit_valid = 1'b1;
        bit_out   = shreg_q[cnt_q];
        if (bit_ready) begin
          if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
          end else if (!empty_w) begin
            pop_w   = 1'b1;
            shreg_d = head_w;
            cnt_d   = 2'd3;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Serializer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      shreg_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  assign dbg_state_o = state_q;

`ifdef QAM_DEMAP_STATS_EN
  logic [15:0] ring_cnt0_q, ring_cnt1_q, ring_cnt2_q;

  // Per-ring decision counters; dropped decisions are counted too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_cnt0_q <= 16'd0;
      ring_cnt1_q <= 16'd0;
      ring_cnt2_q <= 16'd0;
    end else if (s1_valid_q) begin
      case (ring_q)
        2'd0:    ring_cnt0_q <= ring_cnt0_q + 16'd1;
        2'd1:    ring_cnt1_q <= ring_cnt1_q + 16'd1;
        default: ring_cnt2_q <= ring_cnt2_q + 16'd1;
      endcase
    end
  end

  assign ring_cnt0 = ring_cnt0_q;
  assign ring_cnt1 = ring_cnt1_q;
  assign ring_cnt2 = ring_cnt2_q;
`endif

endmodule

// File: tb/tb_qam16_polar_demapper.sv
// Testbench for qam16_polar_demapper: directed vectors, a symbol/bit
// scoreboard driven by a decision model, and a per-cycle compare process.
module tb_qam16_polar_demapper;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        bit_ready = 1'b0;
  logic [17:0] mag_in = '0;
  logic [15:0] phase_in = '0;
  logic        bit_out, bit_valid, sym_valid, ovf, dbg_state;
  logic [3:0]  sym_out;
`ifdef QAM_DEMAP_STATS_EN
  logic [15:0] ring_cnt0, ring_cnt1, ring_cnt2;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  qam16_polar_demapper dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .mag_in      (mag_in),
    .phase_in    (phase_in),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .sym_out     (sym_out),
    .sym_valid   (sym_valid),
    .ovf         (ovf),
    .dbg_state_o (dbg_state)
`ifdef QAM_DEMAP_STATS_EN
    ,
    .ring_cnt0   (ring_cnt0),
    .ring_cnt1   (ring_cnt1),
    .ring_cnt2   (ring_cnt2)
`endif
  );

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad = 0;
  int         bits_seen = 0;
  logic [3:0] exp_q[$];
  int         due_q[$];
  logic       exp_bits_q[$];
  logic       exp_ovf = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- decision model ----------------
  function automatic logic [1:0] gray(input int v);
    if (v == -3)      return 2'b00;
    else if (v == -1) return 2'b01;
    else if (v == 1)  return 2'b11;
    else              return 2'b10;
  endfunction

  function automatic logic [3:0] decide(input int mag, input int ph);
    int ring, q, off, ai, aq, si, sq;
    bit near;
    ring = (mag < 7719) ? 0 : (mag < 12489) ? 1 : 2;
    q    = (ph < 12868) ? 0 : (ph < 25735) ? 1 : (ph < 38603) ? 2 : 3;
    off  = ph - q * 12868;
    near = (off < 6434);
    if (ring == 0) begin
      ai = 1; aq = 1;
    end else if (ring == 2) begin
      ai = 3; aq = 3;
    end else if (q % 2 == 0) begin
      ai = near ? 3 : 1;
      aq = near ? 1 : 3;
    end else begin
      aq = near ? 3 : 1;
      ai = near ? 1 : 3;
    end
    si = (q == 0 || q == 3) ? 1 : -1;
    sq = (q < 2) ? 1 : -1;
    return {gray(si * ai), gray(sq * aq)};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic       ev;
    logic [3:0] e;
    int         held;
    if (rst_n) begin
      if (exp_bits_q.size() == 0) begin
        check("bit_valid_idle", int'(bit_valid), 0);
      end else if (bit_valid && bit_ready) begin
        check("bit_out", int'(bit_out), int'(exp_bits_q.pop_front()));
        bits_seen++;
      end
      check("ovf", int'(ovf), int'(exp_ovf));
      ev = (due_q.size() > 0) && (due_q[0] == cyc);
      check("sym_valid", int'(sym_valid), int'(ev));
      if (ev) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        check("sym_out", int'(sym_out), int'(e));
        held = (exp_bits_q.size() + 3) / 4;
        if (held < DEPTH + 1) begin
          exp_bits_q.push_back(e[3]);
          exp_bits_q.push_back(e[2]);
          exp_bits_q.push_back(e[1]);
          exp_bits_q.push_back(e[0]);
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input int mag, input int ph);
    in_valid = 1'b1;
    mag_in   = 18'(mag);
    phase_in = 16'(ph);
    exp_q.push_back(decide(mag, ph));
    due_q.push_back(cyc + 2);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic vec(input int mag, input int ph, input logic [3:0] lit);
    check("model", int'(decide(mag, ph)), int'(lit));
    put(mag, ph);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bit_valid"}, int'(bit_valid), 0);
    check({tag, "_bit_out"},   int'(bit_out),   0);
    check({tag, "_sym_out"},   int'(sym_out),   0);
    check({tag, "_sym_valid"}, int'(sym_valid), 0);
    check({tag, "_ovf"},       int'(ovf),       0);
  endtask

  // Directed vector table: magnitude, phase, hand-computed symbol.
  int         t_mag [16] = '{10667, 10667, 14310, 14310, 7718, 7719, 12488, 12489,
                             4770, 4770, 10667, 10667, 10667, 10667, 10667, 0};
  int         t_ph  [16] = '{3017, 15885, 32169, 51000, 100, 100, 100, 100,
                             12867, 12868, 6433, 6434, 19302, 25836, 45604, 65535};
  logic [3:0] t_sym [16] = '{4'b1011, 4'b0110, 4'b0000, 4'b1000, 4'b1111, 4'b1011,
                             4'b1011, 4'b1010, 4'b1111, 4'b0111, 4'b1011, 4'b1110,
                             4'b0011, 4'b0001, 4'b1001, 4'b1101};

  // ---------------- main sequence ----------------
  initial begin
    int b0;
    // Reset state.
    idle(2);
    check_all_zero("reset");
    rst_n = 1'b1;
    bit_ready = 1'b1;
    idle(2);

    // First symbol: latency from in_valid edge to first bit.
    vec(4770, 6434, 4'b1111);
    repeat (3) @(negedge clk);
    check("lat_bit_valid_early", int'(bit_valid), 0);
    @(negedge clk);
    check("lat_bit_valid", int'(bit_valid), 1);
    check("lat_bit_out", int'(bit_out), 1);
    idle(8);

    // Directed slicing vectors including ring/quadrant/near boundaries.
    for (int i = 0; i < 16; i++) begin
      vec(t_mag[i], t_ph[i], t_sym[i]);
      idle(5);
    end
    idle(10);
    check("drain_model", exp_bits_q.size(), 0);
    check("drain_bit_valid", int'(bit_valid), 0);
    check("no_ovf", int'(ovf), 0);

    // Back-pressure: six back-to-back symbols, the sixth must be dropped.
    bit_ready = 1'b0;
    for (int i = 0; i < 6; i++) put(t_mag[i], t_ph[i]);
    idle(8);
    check("bp_ovf", int'(ovf), 1);
    check("bp_bit_valid", int'(bit_valid), 1);
    check("bp_held_bits", exp_bits_q.size(), 20);
    b0 = bits_seen;
    bit_ready = 1'b1;
    idle(30);
    check("bp_bits_out", bits_seen - b0, 20);
    check("bp_bit_valid_after", int'(bit_valid), 0);
    check("bp_ovf_sticky", int'(ovf), 1);

    // Asynchronous reset mid-symbol.
    put(14310, 51000);
    put(10667, 15885);
    for (int i = 0; i < 20 && !bit_valid; i++) @(negedge clk);
    check("rst_wait_bit_valid", int'(bit_valid), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    due_q.delete();
    exp_bits_q.delete();
    exp_ovf = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    idle(20);
    check("post_rst_bit_valid", int'(bit_valid), 0);
    check("post_rst_ovf", int'(ovf), 0);

    // Pipeline works again after reset.
    vec(14310, 32169, 4'b0000);
    idle(12);
    check("post_rst_drain", exp_bits_q.size(), 0);
    check("post_rst_sym_out", int'(sym_out), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
